// File: rtl/i2c_target_regs_pkg.sv
// i2c_target_regs_pkg: shared state encoding, default bus address and MPU6050 register map
package i2c_target_regs_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_PTR,
      S_PTR_ACK,
      S_WR_DATA,
      S_WR_ACK,
      S_RD_DATA,
      S_RD_ACK,
      S_IGNORE
   } state_e;

   localparam logic [6:0] DEF_SLAVE_ADDR  = 7'h68;
   localparam logic [7:0] REG_PWR_MGMT_1  = 8'h6B;
   localparam logic [7:0] REG_GYRO_XOUT_H = 8'h43;
   localparam logic [7:0] REG_WHO_AM_I    = 8'h75;

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: SCL/SDA synchronizers with registered SCL edge and START/STOP detection
module i2c_bus_sync
   import i2c_target_regs_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o,
   output logic sda_o
);

   logic [SYNC_STAGES-1:0] scl_sync_q;
   logic [SYNC_STAGES-1:0] sda_sync_q;
   logic                   scl_prev_q;
   logic                   sda_prev_q;
   logic                   scl_s;
   logic                   sda_s;

   assign scl_s = scl_sync_q[SYNC_STAGES-1];
   assign sda_s = sda_sync_q[SYNC_STAGES-1];

   // synchronize the pins (idle bus = 1) and register one-cycle event pulses aligned with the sampled SDA
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
         scl_rise_o <= 1'b0;
         scl_fall_o <= 1'b0;
         start_o    <= 1'b0;
         stop_o     <= 1'b0;
         sda_o      <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
         scl_prev_q <= scl_s;
         sda_prev_q <= sda_s;
         scl_rise_o <= scl_s & ~scl_prev_q;
         scl_fall_o <= ~scl_s & scl_prev_q;
         start_o    <= scl_s & scl_prev_q & sda_prev_q & ~sda_s;
         stop_o     <= scl_s & scl_prev_q & ~sda_prev_q & sda_s;
         sda_o      <= sda_s;
      end
   end

endmodule

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target with a 256x8 register file, auto-incrementing pointer and fabric load port
module i2c_target_regs
   import i2c_target_regs_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR  = DEF_SLAVE_ADDR,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   input  logic       ld_en,
   input  logic [7:0] ld_addr,
   input  logic [7:0] ld_data,
   output logic       wr_valid,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy
);

   logic       scl_rise;
   logic       scl_fall;
   logic       start_det;
   logic       stop_det;
   logic       sda_bit;

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       phase_q, phase_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] ptr_q, ptr_d;
   logic       oe_q, oe_d;
   logic       busy_q, busy_d;
   logic       wr_valid_q, wr_valid_d;
   logic [7:0] wr_addr_q, wr_addr_d;
   logic [7:0] wr_data_q, wr_data_d;

   logic       bus_we;
   logic [7:0] rx_byte;
   logic       addr_match;
   logic       mem_we;
   logic [7:0] mem_waddr;
   logic [7:0] mem_wdata;
   logic [7:0] rd_q;
   logic [7:0] mem [256];

   i2c_bus_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk       (clk),
      .rst       (rst),
      .scl_i     (scl_in),
      .sda_i     (sda_in),
      .scl_rise_o(scl_rise),
      .scl_fall_o(scl_fall),
      .start_o   (start_det),
      .stop_o    (stop_det),
      .sda_o     (sda_bit)
   );

   assign rx_byte    = {shift_q[6:0], sda_bit};
   assign addr_match = rx_byte[7:1] == SLAVE_ADDR;

   // a bus commit takes the single write port; a load in the same cycle is dropped
   assign mem_we    = bus_we | ld_en;
   assign mem_waddr = bus_we ? ptr_q : ld_addr;
   assign mem_wdata = bus_we ? rx_byte : ld_data;

   assign sda_oe   = oe_q;
   assign busy     = busy_q;
   assign wr_valid = wr_valid_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;

   // register file: one write port, registered read of the current pointer for the read shifter
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      rd_q <= mem[ptr_q];
   end

   // protocol state and datapath registers; reset also releases SDA asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         phase_q    <= 1'b0;
         shift_q    <= '0;
         ptr_q      <= '0;
         oe_q       <= 1'b0;
         busy_q     <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         phase_q    <= phase_d;
         shift_q    <= shift_d;
         ptr_q      <= ptr_d;
         oe_q       <= oe_d;
         busy_q     <= busy_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   // next-state: bits sampled on SCL rise, SDA drive changed on SCL fall, START/STOP override all
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      phase_d    = phase_q;
      shift_d    = shift_q;
      ptr_d      = ptr_q;
      oe_d       = oe_q;
      busy_d     = busy_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      bus_we     = 1'b0;
      if (start_det) begin
         state_d = S_ADDR;
         cnt_d   = '0;
         phase_d = 1'b0;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else if (stop_det) begin
         state_d = S_IDLE;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            S_ADDR, S_PTR, S_WR_DATA: begin
               if (scl_rise) begin
                  shift_d = rx_byte;
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     cnt_d   = '0;
                     phase_d = 1'b0;
                     if (state_q == S_ADDR) begin
                        state_d = addr_match ? S_ADDR_ACK : S_IGNORE;
                        busy_d  = addr_match;
                     end else if (state_q == S_PTR) begin
                        state_d = S_PTR_ACK;
                        ptr_d   = rx_byte;
                     end else begin
                        state_d    = S_WR_ACK;
                        bus_we     = 1'b1;
                        wr_valid_d = 1'b1;
                        wr_addr_d  = ptr_q;
                        wr_data_d  = rx_byte;
                        ptr_d      = ptr_q + 8'd1;
                     end
                  end
               end
            end
            S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
               // first fall starts the ACK, second fall ends it and hands over to the next byte
               if (scl_fall) begin
                  phase_d = ~phase_q;
                  oe_d    = ~phase_q;
                  if (phase_q) begin
                     cnt_d   = '0;
                     state_d = (state_q == S_ADDR_ACK) ? S_PTR : S_WR_DATA;
                     if (state_q == S_ADDR_ACK && shift_q[0]) begin
                        state_d = S_RD_DATA;
                        shift_d = rd_q;
                        oe_d    = ~rd_q[7];
                     end
                  end
               end
            end
            S_RD_DATA: begin
               if (scl_rise) begin
                  shift_d = {shift_q[6:0], 1'b0};
                  cnt_d   = cnt_q + 4'd1;
               end else if (scl_fall) begin
                  oe_d = (cnt_q == 4'd8) ? 1'b0 : ~shift_q[7];
                  if (cnt_q == 4'd8) begin
                     state_d = S_RD_ACK;
                     phase_d = 1'b0;
                     cnt_d   = '0;
                  end
               end
            end
            S_RD_ACK: begin
               // pointer advances when the initiator's ACK/NACK is sampled so rd_q is ready by the fall
               if (scl_rise) begin
                  ptr_d   = ptr_q + 8'd1;
                  state_d = sda_bit ? S_IGNORE : S_RD_ACK;
                  phase_d = ~sda_bit;
               end else if (scl_fall && phase_q) begin
                  state_d = S_RD_DATA;
                  shift_d = rd_q;
                  oe_d    = ~rd_q[7];
                  cnt_d   = '0;
                  phase_d = 1'b0;
               end
            end
            default: oe_d = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: transaction-level bus driver with register-file model and scoreboard monitors
module tb_i2c_target_regs;
   import i2c_target_regs_pkg::*;

   localparam int SS = 2;
   localparam int H  = 8;
   localparam logic [7:0] AW = {DEF_SLAVE_ADDR, 1'b0};
   localparam logic [7:0] AR = {DEF_SLAVE_ADDR, 1'b1};

   logic       clk = 1'b0;
   logic       rst;
   logic       scl_drv = 1'b1;
   logic       sda_drv = 1'b1;
   logic       scl_in;
   logic       sda_in;
   logic       sda_oe;
   logic       ld_en = 1'b0;
   logic [7:0] ld_addr = '0;
   logic [7:0] ld_data = '0;
   logic       wr_valid;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] model_mem [256];
   logic [7:0] model_ptr = '0;
   logic [15:0] exp_wr[$];
   logic [7:0] exp_rd[$];
   logic [7:0] obs_rd[$];
   logic [7:0] tx_buf [8];
   bit         saw_oe, saw_busy, saw_wr;

   assign scl_in = scl_drv;
   assign sda_in = sda_drv & ~sda_oe;

   i2c_target_regs #(
      .SLAVE_ADDR (DEF_SLAVE_ADDR),
      .SYNC_STAGES(SS)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .scl_in  (scl_in),
      .sda_in  (sda_in),
      .sda_oe  (sda_oe),
      .ld_en   (ld_en),
      .ld_addr (ld_addr),
      .ld_data (ld_data),
      .wr_valid(wr_valid),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .busy    (busy)
   );

   always #10 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
      end
   endtask

   // scoreboard monitors: write events from the DUT port, read bytes as observed on the bus
   always @(negedge clk) begin
      if (sda_oe) saw_oe = 1'b1;
      if (busy) saw_busy = 1'b1;
      if (wr_valid) saw_wr = 1'b1;
      if (rst && wr_valid) begin
         if (exp_wr.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL wr_unexpected actual addr=%02h data=%02h expected no event", wr_addr, wr_data);
         end else begin
            logic [15:0] e;
            e = exp_wr.pop_front();
            chk("wr_addr", wr_addr, e[15:8]);
            chk("wr_data", wr_data, e[7:0]);
         end
      end
      while (obs_rd.size() > 0) begin
         logic [7:0] o;
         o = obs_rd.pop_front();
         if (exp_rd.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rd_unexpected actual=%02h expected no byte", o);
         end else chk("rd_data", o, exp_rd.pop_front());
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic w(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input logic [7:0] a, input logic [7:0] d);
      ld_en = 1'b1;
      ld_addr = a;
      ld_data = d;
      w(1);
      ld_en = 1'b0;
      model_mem[a] = d;
   endtask

   task automatic i2c_start();
      sda_drv = 1'b1; w(H);
      scl_drv = 1'b1; w(H);
      sda_drv = 1'b0; w(H);
      scl_drv = 1'b0; w(H);
   endtask

   task automatic i2c_stop();
      sda_drv = 1'b0; w(H);
      scl_drv = 1'b1; w(H);
      sda_drv = 1'b1; w(H);
   endtask

   // collide: pulse a load of 0x99 to 0x00 in the cycle the target commits this bit
   task automatic wbit(input bit b, input bit collide);
      sda_drv = b;
      w(H);
      scl_drv = 1'b1;
      if (collide) begin
         w(SS + 1);
         ld_en = 1'b1;
         ld_addr = 8'h00;
         ld_data = 8'h99;
         w(1);
         ld_en = 1'b0;
         w(H - SS - 2);
      end else w(H);
      scl_drv = 1'b0;
      w(H);
   endtask

   task automatic rbit(output bit b);
      sda_drv = 1'b1;
      w(H);
      scl_drv = 1'b1;
      w(H / 2);
      b = sda_in;
      w(H / 2);
      scl_drv = 1'b0;
      w(H);
   endtask

   task automatic wbyte(input logic [7:0] d, input bit exp_ack, input bit collide, input string name);
      bit a;
      for (int i = 7; i >= 0; i--) wbit(d[i], collide && i == 0);
      rbit(a);
      chk(name, {7'b0, ~a}, {7'b0, exp_ack});
   endtask

   task automatic rbyte(input bit nack, output logic [7:0] d);
      bit b;
      for (int i = 7; i >= 0; i--) begin
         rbit(b);
         d[i] = b;
      end
      wbit(nack, 1'b0);
   endtask

   task automatic bus_write(input logic [7:0] p, input int n, input int collide_idx);
      i2c_start();
      wbyte(AW, 1'b1, 1'b0, "ack_addr_w");
      chk("busy_match", {7'b0, busy}, 8'h01);
      wbyte(p, 1'b1, 1'b0, "ack_ptr");
      model_ptr = p;
      for (int i = 0; i < n; i++) begin
         exp_wr.push_back({model_ptr, tx_buf[i]});
         model_mem[model_ptr] = tx_buf[i];
         model_ptr++;
         wbyte(tx_buf[i], 1'b1, i == collide_idx, "ack_data");
      end
      i2c_stop();
      chk("busy_after_stop", {7'b0, busy}, 8'h00);
   endtask

   task automatic bus_read(input bit set_ptr, input logic [7:0] p, input int n);
      logic [7:0] d;
      if (set_ptr) begin
         i2c_start();
         wbyte(AW, 1'b1, 1'b0, "ack_addr_w");
         wbyte(p, 1'b1, 1'b0, "ack_ptr");
         model_ptr = p;
      end
      i2c_start();
      wbyte(AR, 1'b1, 1'b0, "ack_addr_r");
      for (int i = 0; i < n; i++) begin
         exp_rd.push_back(model_mem[model_ptr]);
         model_ptr++;
         rbyte(i == n - 1, d);
         obs_rd.push_back(d);
      end
      i2c_stop();
   endtask

   initial begin
      logic [7:0] a8;
      bit b;
      int k;
      rst = 1'b0;
      w(4);
      chk("rst_sda_oe", {7'b0, sda_oe}, 8'h00);
      chk("rst_busy", {7'b0, busy}, 8'h00);
      chk("rst_wr_valid", {7'b0, wr_valid}, 8'h00);
      chk("rst_wr_addr", wr_addr, 8'h00);
      chk("rst_wr_data", wr_data, 8'h00);
      rst = 1'b1;
      w(4);
      for (int i = 0; i < 256; i++) load(i[7:0], 8'($urandom));
      load(REG_WHO_AM_I, 8'h68);

      // MPU6050 power-management write
      tx_buf[0] = 8'h01;
      bus_write(REG_PWR_MGMT_1, 1, -1);
      bus_read(1'b1, REG_PWR_MGMT_1, 1);

      // pointer write, repeated START, two-byte burst read, then read continues at 0x45
      load(REG_GYRO_XOUT_H, 8'hA5);
      load(8'h44, 8'h3C);
      bus_read(1'b1, REG_GYRO_XOUT_H, 2);
      bus_read(1'b0, 8'h00, 1);

      // foreign address is never acknowledged and leaves no trace
      w(2);
      saw_oe = 1'b0;
      saw_busy = 1'b0;
      saw_wr = 1'b0;
      i2c_start();
      wbyte(8'hA0, 1'b0, 1'b0, "nack_foreign_addr");
      wbyte(8'h00, 1'b0, 1'b0, "nack_foreign_data");
      i2c_stop();
      chk("foreign_sda_oe", {7'b0, saw_oe}, 8'h00);
      chk("foreign_busy", {7'b0, saw_busy}, 8'h00);
      chk("foreign_wr_valid", {7'b0, saw_wr}, 8'h00);

      // pointer wrap with a colliding load on the second commit
      tx_buf[0] = 8'h11;
      tx_buf[1] = 8'h22;
      bus_write(8'hFF, 2, 1);
      bus_read(1'b1, 8'hFF, 2);

      // STOP after four data bits discards the partial byte
      i2c_start();
      wbyte(AW, 1'b1, 1'b0, "ack_addr_w");
      wbyte(8'h10, 1'b1, 1'b0, "ack_ptr");
      model_ptr = 8'h10;
      for (int i = 0; i < 4; i++) wbit(1'($urandom), 1'b0);
      i2c_stop();
      chk("busy_stop_midbyte", {7'b0, busy}, 8'h00);
      bus_read(1'b1, 8'h10, 1);

      // reset while the address ACK is driven
      i2c_start();
      a8 = AW;
      for (int i = 7; i >= 0; i--) wbit(a8[i], 1'b0);
      k = 0;
      while (!sda_oe && k < 20) begin
         w(1);
         k++;
      end
      chk("oe_before_reset", {7'b0, sda_oe}, 8'h01);
      #3;
      rst = 1'b0;
      #1;
      chk("oe_async_reset", {7'b0, sda_oe}, 8'h00);
      model_ptr = 8'h00;
      w(3);
      rst = 1'b1;
      w(2);
      saw_busy = 1'b0;
      saw_wr = 1'b0;
      rbit(b);
      chk("ack_after_reset", {7'b0, b}, 8'h01);
      wbyte(REG_PWR_MGMT_1, 1'b0, 1'b0, "nack_after_reset");
      wbyte(8'h55, 1'b0, 1'b0, "nack_after_reset");
      chk("busy_after_reset", {7'b0, saw_busy}, 8'h00);
      chk("wr_after_reset", {7'b0, saw_wr}, 8'h00);
      i2c_stop();
      bus_read(1'b0, 8'h00, 1);

      // randomized mix of loads, burst writes and burst reads
      for (int t = 0; t < 14; t++) begin
         int kind;
         int n;
         kind = $urandom_range(0, 3);
         n = $urandom_range(1, 4);
         case (kind)
            0: load(8'($urandom), 8'($urandom));
            1: begin
               for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
               bus_write(8'($urandom), n, -1);
            end
            2: bus_read(1'b1, 8'($urandom), n);
            default: bus_read(1'b0, 8'h00, n);
         endcase
      end

      w(4);
      chk("wr_pending", 8'(exp_wr.size()), 8'h00);
      chk("rd_pending", 8'(exp_rd.size()), 8'h00);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
